wb_led_sequencer: RTL and testbench

- Wishbone classic master that periodically drives the 6-bit LED peripheral at address 0x00.
- On each prescaler tick it computes the next LED pattern, writes it, reads it back and compares.
- Flags readback mismatches and ack timeouts as sticky errors.
- Sits between board-level controls (enable/mode switches) and the LED slave on the on-chip Wishbone bus.

---
 rtl/wb_led_sequencer.sv | 262 ++++++++++++++++++++++++++
 tb/tb_wb_led_sequencer.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_led_sequencer.sv
// -----------------------------------------------------------------------------
// wb_led_sequencer
//
// Wishbone classic master that steps a LED pattern once per prescaler tick.
// Each step writes the new pattern to the LED slave at LED_ADDR, reads it back
// and compares. Readback mismatches and ack timeouts raise sticky error flags.
//
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_enable              run the sequencer when high
//   i_mode                0=count, 1=rotate, 2=bounce, 3=static
//   i_static_pattern      pattern loaded in static mode
//   i_err_clr             single-cycle pulse clearing both error flags
//   o_wb_cyc/stb/we       Wishbone request controls (registered)
//   o_wb_addr             constant LED_ADDR
//   o_wb_data             write data (the pattern being written)
//   i_wb_ack/stall/data   Wishbone slave response
//   o_pattern             last pattern issued
//   o_busy                high in WR_REQ, RD_REQ and GAP
//   o_err_mismatch        sticky readback mismatch
//   o_err_timeout         sticky ack timeout
//
// Handshake: a request is presented with cyc=stb=1 and held unchanged until
// the slave returns ack (stall only stretches the wait). The request ends in
// the cycle ack is seen, or after TIMEOUT_CYCLES cycles without ack. Acks
// arriving while no request is outstanding are ignored.
// -----------------------------------------------------------------------------
module wb_led_sequencer #(
    parameter int                    ADDR_WIDTH     = 8,
    parameter int                    DATA_WIDTH     = 6,
    parameter int                    TICK_DIV       = 13500000,
    parameter int                    TIMEOUT_CYCLES = 16,
    parameter int                    GAP_CYCLES     = 2,
    parameter logic [ADDR_WIDTH-1:0] LED_ADDR       = 'h00
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_enable,
    input  logic [1:0]            i_mode,
    input  logic [DATA_WIDTH-1:0] i_static_pattern,
    input  logic                  i_err_clr,
    output logic                  o_wb_cyc,
    output logic                  o_wb_stb,
    output logic                  o_wb_we,
    output logic [ADDR_WIDTH-1:0] o_wb_addr,
    output logic [DATA_WIDTH-1:0] o_wb_data,
    input  logic                  i_wb_ack,
    input  logic                  i_wb_stall,
    input  logic [DATA_WIDTH-1:0] i_wb_data,
    output logic [DATA_WIDTH-1:0] o_pattern,
    output logic                  o_busy,
    output logic                  o_err_mismatch,
    output logic                  o_err_timeout
);

    localparam int PRESC_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int TMO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GAP_W   = $clog2(GAP_CYCLES + 1);
    localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);
    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_TICK,
        ST_WR_REQ,
        ST_RD_REQ,
        ST_GAP
    } state_e;

    state_e                state_q, state_d;
    state_e                after_gap_q, after_gap_d;
    logic [PRESC_W-1:0]    presc_q, presc_d;
    logic [TMO_W-1:0]      tmo_q, tmo_d;
    logic [GAP_W-1:0]      gap_q, gap_d;
    logic [DATA_WIDTH-1:0] pattern_q, pattern_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  dir_q, dir_d;
    logic                  cyc_q, cyc_d;
    logic                  we_q, we_d;
    logic                  busy_q, busy_d;
    logic                  mism_q, mism_d;
    logic                  tmo_err_q, tmo_err_d;
    logic                  set_mismatch, set_timeout;

    // Stall needs no action: the request registers simply hold while waiting.
    logic unused_stall;
    assign unused_stall = i_wb_stall;

    // -------------------------------------------------------------------------
    // Next-pattern computation (mode sampled when the tick fires)
    // -------------------------------------------------------------------------
    logic                  pat_one_hot;
    logic                  bounce_right;
    logic [DATA_WIDTH-1:0] next_pat;
    logic                  next_dir;

    assign pat_one_hot = (pattern_q != '0) && ((pattern_q & (pattern_q - ONE)) == '0);

    // At either end the direction is forced, so a one-hot pattern left over
    // from another mode can never be shifted off the edge.
    assign bounce_right = pattern_q[DATA_WIDTH-1] ? DIR_RIGHT :
                          (pattern_q[0] ? DIR_LEFT : dir_q);

    always_comb begin
        next_pat = pattern_q;
        next_dir = dir_q;
        unique case (i_mode)
            2'd0: next_pat = pattern_q + ONE;
            2'd1: next_pat = pat_one_hot ? {pattern_q[DATA_WIDTH-2:0], pattern_q[DATA_WIDTH-1]} : ONE;
            2'd2: begin
                if (!pat_one_hot) begin
                    next_pat = ONE;
                    next_dir = DIR_LEFT;
                end else begin
                    next_pat = bounce_right ? (pattern_q >> 1) : (pattern_q << 1);
                    if (next_pat[DATA_WIDTH-1]) begin
                        next_dir = DIR_RIGHT;
                    end else if (next_pat[0]) begin
                        next_dir = DIR_LEFT;
                    end else begin
                        next_dir = bounce_right;
                    end
                end
            end
            default: next_pat = i_static_pattern;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM next state
    // -------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        after_gap_d  = after_gap_q;
        presc_d      = presc_q;
        tmo_d        = tmo_q;
        gap_d        = gap_q;
        pattern_d    = pattern_q;
        wdata_d      = wdata_q;
        dir_d        = dir_q;
        set_mismatch = 1'b0;
        set_timeout  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (i_enable) begin
                    state_d = ST_WAIT_TICK;
                    presc_d = '0;
                end
            end
            ST_WAIT_TICK: begin
                if (!i_enable) begin
                    state_d = ST_IDLE;
                end else if (presc_q == PRESC_W'(TICK_DIV - 1)) begin
                    presc_d   = '0;
                    pattern_d = next_pat;
                    wdata_d   = next_pat;
                    dir_d     = next_dir;
                    tmo_d     = '0;
                    state_d   = ST_WR_REQ;
                end else begin
                    presc_d = presc_q + PRESC_W'(1);
                end
            end
            ST_WR_REQ: begin
                if (i_wb_ack) begin
                    state_d     = ST_GAP;
                    gap_d       = '0;
                    after_gap_d = ST_RD_REQ;
                end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    // The read-back is skipped after a write timeout.
                    set_timeout = 1'b1;
                    state_d     = ST_GAP;
                    gap_d       = '0;
                    after_gap_d = i_enable ? ST_WAIT_TICK : ST_IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_RD_REQ: begin
                if (i_wb_ack) begin
                    set_mismatch = (i_wb_data != pattern_q);
                    state_d      = ST_GAP;
                    gap_d        = '0;
                    after_gap_d  = i_enable ? ST_WAIT_TICK : ST_IDLE;
                end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    set_timeout = 1'b1;
                    state_d     = ST_GAP;
                    gap_d       = '0;
                    after_gap_d = i_enable ? ST_WAIT_TICK : ST_IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
                    state_d = after_gap_q;
                    tmo_d   = '0;
                    presc_d = '0;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Bus controls and busy are decoded from the next state so they line up
    // with the state register on the same edge.
    always_comb begin
        cyc_d     = (state_d == ST_WR_REQ) || (state_d == ST_RD_REQ);
        we_d      = (state_d == ST_WR_REQ);
        busy_d    = cyc_d || (state_d == ST_GAP);
        // A set event in the same cycle as a clear wins.
        mism_d    = set_mismatch || (mism_q && !i_err_clr);
        tmo_err_d = set_timeout || (tmo_err_q && !i_err_clr);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            after_gap_q <= ST_IDLE;
            presc_q     <= '0;
            tmo_q       <= '0;
            gap_q       <= '0;
            pattern_q   <= '0;
            wdata_q     <= '0;
            dir_q       <= DIR_LEFT;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            busy_q      <= 1'b0;
            mism_q      <= 1'b0;
            tmo_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            after_gap_q <= after_gap_d;
            presc_q     <= presc_d;
            tmo_q       <= tmo_d;
            gap_q       <= gap_d;
            pattern_q   <= pattern_d;
            wdata_q     <= wdata_d;
            dir_q       <= dir_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            busy_q      <= busy_d;
            mism_q      <= mism_d;
            tmo_err_q   <= tmo_err_d;
        end
    end

    assign o_wb_cyc       = cyc_q;
    assign o_wb_stb       = cyc_q;
    assign o_wb_we        = we_q;
    assign o_wb_addr      = LED_ADDR;
    assign o_wb_data      = wdata_q;
    assign o_pattern      = pattern_q;
    assign o_busy         = busy_q;
    assign o_err_mismatch = mism_q;
    assign o_err_timeout  = tmo_err_q;

endmodule

// File: tb/tb_wb_led_sequencer.sv
// Bench for wb_led_sequencer with TICK_DIV=4, TIMEOUT_CYCLES=16, GAP_CYCLES=2.
// A behavioural LED slave acks ACK_DELAY negedges after a request is seen.
module tb_wb_led_sequencer;

    localparam int AW             = 8;
    localparam int DW             = 6;
    localparam int TICK_DIV       = 4;
    localparam int TIMEOUT_CYCLES = 16;
    localparam int GAP_CYCLES     = 2;
    localparam int ACK_DELAY      = 2;
    // write start to next write start: 3 (write) + 2 (gap) + 3 (read) + 2 (gap) + 4 (tick)
    localparam int TX_SPACING     = 14;

    localparam int EV_WRITE    = 0;
    localparam int EV_READ     = 1;
    localparam int EV_STB_HIGH = 2;
    localparam int EV_RD_STB   = 3;

    // ---------------- clock / reset / DUT ----------------
    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          i_enable = 1'b0;
    logic [1:0]    i_mode = 2'd0;
    logic [DW-1:0] i_static_pattern = '0;
    logic          i_err_clr = 1'b0;
    logic          o_wb_cyc, o_wb_stb, o_wb_we;
    logic [AW-1:0] o_wb_addr;
    logic [DW-1:0] o_wb_data;
    logic          i_wb_ack = 1'b0;
    logic          i_wb_stall = 1'b0;
    logic [DW-1:0] i_wb_data = '0;
    logic [DW-1:0] o_pattern;
    logic          o_busy, o_err_mismatch, o_err_timeout;

    always #5 i_clk = ~i_clk;

    wb_led_sequencer #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TICK_DIV(TICK_DIV),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .GAP_CYCLES(GAP_CYCLES), .LED_ADDR(8'h00)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_enable(i_enable), .i_mode(i_mode),
        .i_static_pattern(i_static_pattern), .i_err_clr(i_err_clr),
        .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
        .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data),
        .i_wb_ack(i_wb_ack), .i_wb_stall(i_wb_stall), .i_wb_data(i_wb_data),
        .o_pattern(o_pattern), .o_busy(o_busy),
        .o_err_mismatch(o_err_mismatch), .o_err_timeout(o_err_timeout)
    );

    // ---------------- slave model controls (written by main only) ----------------
    bit            ack_en = 1'b1;
    logic [DW-1:0] corrupt_mask = '0;
    int            stall_cycles = 0;
    bit            dup_en = 1'b0;
    int            stray_cnt = 0;

    // ---------------- slave model state (written by slave only) ----------------
    int            cyc_n = 0;
    int            wr_cnt = 0;
    int            rd_cnt = 0;
    logic [DW-1:0] wr_data_log [256];
    logic [AW-1:0] wr_addr_log [256];
    int            wr_start_log [256];
    logic [DW-1:0] led_reg = '0;
    int            w = 0;
    bit            active = 1'b0;
    int            start_cyc = 0;
    int            stall_left = 0;
    int            stall_seen = 0;
    int            stall_bad = 0;
    logic [DW:0]   snap = '0;
    bit            dup_pending = 1'b0;
    int            stray_seen = 0;

    always @(negedge i_clk) begin
        cyc_n = cyc_n + 1;
        if (i_wb_ack) begin
            if (dup_pending) dup_pending = 1'b0;
            else i_wb_ack = 1'b0;
            active = 1'b0;
            i_wb_stall = 1'b0;
        end else if (stray_cnt != stray_seen) begin
            i_wb_ack = 1'b1;
            stray_seen = stray_seen + 1;
        end else if (o_wb_cyc && o_wb_stb) begin
            if (!active) begin
                active = 1'b1;
                w = 0;
                start_cyc = cyc_n;
                snap = {o_wb_we, o_wb_data};
                stall_left = o_wb_we ? stall_cycles : 0;
            end
            if (stall_left > 0) begin
                i_wb_stall = 1'b1;
                stall_left = stall_left - 1;
                stall_seen = stall_seen + 1;
                if ({o_wb_we, o_wb_data} != snap) stall_bad = stall_bad + 1;
            end else begin
                i_wb_stall = 1'b0;
                if (ack_en && w == ACK_DELAY) begin
                    i_wb_ack = 1'b1;
                    if (o_wb_we) begin
                        led_reg = o_wb_data;
                        wr_data_log[wr_cnt % 256]  = o_wb_data;
                        wr_addr_log[wr_cnt % 256]  = o_wb_addr;
                        wr_start_log[wr_cnt % 256] = start_cyc;
                        wr_cnt = wr_cnt + 1;
                        dup_pending = dup_en;
                    end else begin
                        i_wb_data = led_reg ^ corrupt_mask;
                        rd_cnt = rd_cnt + 1;
                    end
                end else if (w < ACK_DELAY) begin
                    w = w + 1;
                end
            end
        end else begin
            active = 1'b0;
            i_wb_stall = 1'b0;
        end
    end

    // ---------------- scoreboard ----------------
    int            checks = 0;
    int            failures = 0;
    logic [DW-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks = checks + 1;
        if (actual !== expected) begin
            failures = failures + 1;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic wait_event(input int kind, input int budget, input string name);
        int wr0, rd0;
        bit hit;
        wr0 = wr_cnt;
        rd0 = rd_cnt;
        hit = 1'b0;
        for (int n = 0; n < budget && !hit; n++) begin
            @(negedge i_clk);
            #1;
            case (kind)
                EV_WRITE:    hit = (wr_cnt != wr0);
                EV_READ:     hit = (rd_cnt != rd0);
                EV_STB_HIGH: hit = o_wb_stb;
                default:     hit = o_wb_stb && !o_wb_we;
            endcase
        end
        checks = checks + 1;
        if (!hit) begin
            failures = failures + 1;
            $display("FAIL %s: event not seen within %0d cycles", name, budget);
        end
    endtask

    function automatic int last_wr();
        return (wr_cnt - 1) % 256;
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        logic [1:0]    mode;
        logic [DW-1:0] stat;
        logic [DW-1:0] exp;
    } vec_t;
    vec_t vecs[$];

    task automatic add_vec(input logic [1:0] m, input logic [DW-1:0] s, input logic [DW-1:0] e);
        vec_t v;
        v.mode = m;
        v.stat = s;
        v.exp  = e;
        vecs.push_back(v);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int prev_start, idx, n, rd0, stall0, wr0;
        logic [DW-1:0] exp;

        // count from reset, count wrap 63->0, rotate, bounce, static
        add_vec(2'd0, 6'd0, 6'd1);
        add_vec(2'd0, 6'd0, 6'd2);
        add_vec(2'd0, 6'd0, 6'd3);
        add_vec(2'd3, 6'd62, 6'd62);
        add_vec(2'd0, 6'd0, 6'd63);
        add_vec(2'd0, 6'd0, 6'd0);
        add_vec(2'd1, 6'd0, 6'd1);
        add_vec(2'd1, 6'd0, 6'd2);
        add_vec(2'd1, 6'd0, 6'd4);
        add_vec(2'd1, 6'd0, 6'd8);
        add_vec(2'd1, 6'd0, 6'd16);
        add_vec(2'd1, 6'd0, 6'd32);
        add_vec(2'd1, 6'd0, 6'd1);
        add_vec(2'd3, 6'd5, 6'd5);
        add_vec(2'd2, 6'd0, 6'd1);
        add_vec(2'd2, 6'd0, 6'd2);
        add_vec(2'd2, 6'd0, 6'd4);
        add_vec(2'd2, 6'd0, 6'd8);
        add_vec(2'd2, 6'd0, 6'd16);
        add_vec(2'd2, 6'd0, 6'd32);
        add_vec(2'd2, 6'd0, 6'd16);
        add_vec(2'd2, 6'd0, 6'd8);
        add_vec(2'd2, 6'd0, 6'd4);
        add_vec(2'd2, 6'd0, 6'd2);
        add_vec(2'd2, 6'd0, 6'd1);
        add_vec(2'd2, 6'd0, 6'd2);
        add_vec(2'd3, 6'd42, 6'd42);

        // ---- reset state ----
        repeat (3) @(negedge i_clk);
        #1;
        check("rst_cyc", o_wb_cyc, 0);
        check("rst_stb", o_wb_stb, 0);
        check("rst_we", o_wb_we, 0);
        check("rst_wdata", o_wb_data, 0);
        check("rst_pattern", o_pattern, 0);
        check("rst_busy", o_busy, 0);
        check("rst_errs", {o_err_mismatch, o_err_timeout}, 0);
        check("rst_addr", o_wb_addr, 0);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        #1;
        i_enable = 1'b1;

        // ---- table-driven pattern sequence ----
        prev_start = 0;
        for (int i = 0; i < vecs.size(); i++) begin
            i_mode = vecs[i].mode;
            i_static_pattern = vecs[i].stat;
            exp_q.push_back(vecs[i].exp);
            wait_event(EV_WRITE, 200, "table_write");
            idx = last_wr();
            exp = exp_q.pop_front();
            check("table_wr_data", wr_data_log[idx], exp);
            check("table_wr_addr", wr_addr_log[idx], 0);
            check("table_o_pattern", o_pattern, exp);
            check("table_no_errs", {o_err_mismatch, o_err_timeout}, 0);
            if (i > 0) check("table_spacing", wr_start_log[idx] - prev_start, TX_SPACING);
            prev_start = wr_start_log[idx];
        end

        // ---- stray ack while waiting for the tick ----
        i_mode = 2'd3;
        i_static_pattern = 6'd21;
        wait_event(EV_READ, 100, "stray_read");
        repeat (4) @(negedge i_clk);
        #1;
        stray_cnt = stray_cnt + 1;
        repeat (2) @(negedge i_clk);
        #1;
        check("stray_cyc", o_wb_cyc, 0);
        check("stray_busy", o_busy, 0);
        wait_event(EV_WRITE, 100, "stray_write");
        idx = last_wr();
        check("stray_wr_data", wr_data_log[idx], 21);
        check("stray_spacing", wr_start_log[idx] - prev_start, TX_SPACING);
        prev_start = wr_start_log[idx];

        // ---- write stalled 5 cycles, duplicate ack during GAP ----
        rd0 = rd_cnt;
        stall0 = stall_seen;
        stall_cycles = 5;
        dup_en = 1'b1;
        i_static_pattern = 6'd22;
        wait_event(EV_WRITE, 100, "stall_write");
        stall_cycles = 0;
        dup_en = 1'b0;
        idx = last_wr();
        check("stall_wr_data", wr_data_log[idx], 22);
        check("stall_spacing", wr_start_log[idx] - prev_start, TX_SPACING);
        check("stall_cycles_seen", stall_seen - stall0, 5);
        check("stall_req_stable", stall_bad, 0);
        prev_start = wr_start_log[idx];
        i_static_pattern = 6'd23;
        wait_event(EV_WRITE, 100, "post_stall_write");
        idx = last_wr();
        check("post_stall_wr_data", wr_data_log[idx], 23);
        check("post_stall_spacing", wr_start_log[idx] - prev_start, TX_SPACING + 5);
        check("dup_ack_read_count", rd_cnt - rd0, 2);
        check("dup_ack_no_errs", {o_err_mismatch, o_err_timeout}, 0);

        // ---- ack timeout on write ----
        wait_event(EV_READ, 100, "pre_tmo_read");
        ack_en = 1'b0;
        wait_event(EV_STB_HIGH, 100, "tmo_rise");
        n = 0;
        while (o_wb_stb && n < 40) begin
            n++;
            @(negedge i_clk);
            #1;
        end
        check("tmo_stb_cycles", n, TIMEOUT_CYCLES);
        check("tmo_flag", o_err_timeout, 1);
        check("tmo_cyc_low", o_wb_cyc, 0);
        n = 0;
        while (!o_wb_stb && n < 40) begin
            n++;
            @(negedge i_clk);
            #1;
        end
        check("tmo_low_until_retry", n, GAP_CYCLES + TICK_DIV);
        check("tmo_retry_is_write", o_wb_we, 1);
        check("tmo_no_mismatch", o_err_mismatch, 0);
        ack_en = 1'b1;
        wait_event(EV_WRITE, 100, "tmo_retry_write");
        check("tmo_retry_data", wr_data_log[last_wr()], 23);

        // ---- readback mismatch, clear, re-set, set-wins-over-clear ----
        corrupt_mask = 6'b000001;
        wait_event(EV_READ, 100, "mm_read1");
        @(negedge i_clk);
        #1;
        check("mm_set", o_err_mismatch, 1);
        i_err_clr = 1'b1;
        @(negedge i_clk);
        #1;
        i_err_clr = 1'b0;
        check("mm_clr", o_err_mismatch, 0);
        check("tmo_clr", o_err_timeout, 0);
        wait_event(EV_READ, 100, "mm_read2");
        @(negedge i_clk);
        #1;
        check("mm_reset", o_err_mismatch, 1);
        i_err_clr = 1'b1;
        wait_event(EV_READ, 100, "mm_read3");
        @(negedge i_clk);
        #1;
        check("mm_set_wins", o_err_mismatch, 1);
        @(negedge i_clk);
        #1;
        check("mm_clr_after", o_err_mismatch, 0);
        i_err_clr = 1'b0;

        // ---- asynchronous reset in the middle of a write ----
        wait_event(EV_READ, 100, "mm_read4");
        ack_en = 1'b0;
        @(negedge i_clk);
        #1;
        check("pre_rst_mm", o_err_mismatch, 1);
        wait_event(EV_STB_HIGH, 100, "rst_wr_rise");
        check("rst_mid_we", o_wb_we, 1);
        #1;
        i_rst_n = 1'b0;
        #1;
        check("arst_cyc", o_wb_cyc, 0);
        check("arst_stb", o_wb_stb, 0);
        check("arst_we", o_wb_we, 0);
        check("arst_errs", {o_err_mismatch, o_err_timeout}, 0);
        check("arst_pattern", o_pattern, 0);
        check("arst_wdata", o_wb_data, 0);
        check("arst_busy", o_busy, 0);
        ack_en = 1'b1;
        corrupt_mask = '0;
        i_mode = 2'd1;
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;

        // ---- enable dropped during the read ----
        wait_event(EV_WRITE, 100, "post_rst_write");
        check("post_rst_rotate", wr_data_log[last_wr()], 1);
        wait_event(EV_RD_STB, 50, "dis_rd_rise");
        i_enable = 1'b0;
        wait_event(EV_READ, 50, "dis_read_done");
        repeat (10) @(negedge i_clk);
        #1;
        check("dis_busy", o_busy, 0);
        check("dis_cyc", o_wb_cyc, 0);
        check("dis_no_errs", {o_err_mismatch, o_err_timeout}, 0);
        wr0 = wr_cnt;
        repeat (20) @(negedge i_clk);
        #1;
        check("dis_no_writes", wr_cnt - wr0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
